// File: rtl/steer_pkg.sv
// Shared types and the wrap-aware angle error helper
// for the multi-channel steering controller.
package steer_pkg;

    localparam int MAXW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    typedef struct packed {
        logic            dir;
        logic [MAXW-1:0] mag;
    } err_t;

    // Shortest path on a 2^w ring; the half-turn tie resolves negative.
    function automatic err_t calc_err(
        input logic [MAXW-1:0] tgt,
        input logic [MAXW-1:0] cur,
        input int              w
    );
        logic [MAXW:0] span;
        logic [MAXW:0] diff;
        logic [MAXW:0] neg;
        err_t          e;
        span  = {{MAXW{1'b0}}, 1'b1} << w;
        diff  = ({1'b0, tgt} - {1'b0, cur}) & (span - 1'b1);
        neg   = span - diff;
        e.dir = ~diff[w-1];
        e.mag = e.dir ? diff[MAXW-1:0] : neg[MAXW-1:0];
        return e;
    endfunction

endpackage

// File: rtl/steer_ch.sv
// One steering channel: encoder sync/capture, angle FSM,
// PWM ratio ramp and single-outstanding update handshake.
module steer_ch
    import steer_pkg::*;
#(
    parameter int ANGLE_W       = 12,
    parameter int PWM_W         = 8,
    parameter int MIN_PWM       = 40,
    parameter int MAX_PWM       = 200,
    parameter int RAMP_STEP     = 8,
    parameter int SLOW_ZONE     = 128,
    parameter int TOL           = 8,
    parameter int CONSEC        = 3,
    parameter int STALL_SAMPLES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [ANGLE_W-1:0] i_tgt,
    input  logic               i_upd,
    input  logic               i_abort,
    input  logic               i_enc_valid,
    input  logic [ANGLE_W-1:0] i_enc_angle,
    input  logic               i_pwm_done,
    output logic [ANGLE_W-1:0] o_cur,
    output logic               o_done,
    output logic               o_fail,
    output logic               o_en,
    output logic               o_dir,
    output logic [PWM_W-1:0]   o_ratio,
    output logic               o_upd
);

    localparam int OW = $clog2(CONSEC + 1);
    localparam int SW = $clog2(STALL_SAMPLES + 1);
    localparam logic [PWM_W-1:0] L_MIN  = PWM_W'(MIN_PWM);
    localparam logic [PWM_W-1:0] L_MAX  = PWM_W'(MAX_PWM);
    localparam logic [PWM_W:0]   L_STEP = (PWM_W+1)'(RAMP_STEP);
    localparam logic [MAXW-1:0]  L_SLOW = MAXW'(SLOW_ZONE);
    localparam logic [MAXW-1:0]  L_TOL  = MAXW'(TOL);
    localparam logic [OW-1:0]    L_CONS = OW'(CONSEC);
    localparam logic [SW-1:0]    L_STAL = SW'(STALL_SAMPLES);

    logic [2:0]         r_sync;
    logic               w_rise;
    logic               r_sample;
    logic [ANGLE_W-1:0] r_cur;
    logic [ANGLE_W-1:0] r_tgt, w_tgt;
    state_t             r_state, w_state;
    logic [PWM_W-1:0]   r_ratio, w_ratio;
    logic               r_dir, w_dir;
    logic               r_en, w_en;
    logic               r_done, w_done;
    logic               r_fail, w_fail;
    logic [OW-1:0]      r_ont, w_ont, w_ont_inc;
    logic [SW-1:0]      r_stall, w_stall, w_stall_inc;
    logic [MAXW-1:0]    r_prev, w_prev;
    logic               w_req;
    logic               r_pend, r_defer, r_upd;
    err_t               w_err_new, w_err_run;
    logic [PWM_W-1:0]   w_goal, w_ramp;
    logic [PWM_W:0]     w_up;
    logic               w_ontgt, w_worse;

    assign w_rise = r_sync[1] & ~r_sync[2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_sample <= 1'b0;
            r_cur    <= '0;
        end else begin
            r_sync   <= {r_sync[1:0], i_enc_valid};
            r_sample <= w_rise;
            if (w_rise) r_cur <= i_enc_angle;
        end
    end

    assign w_err_new   = calc_err(MAXW'(i_tgt), MAXW'(r_cur), ANGLE_W);
    assign w_err_run   = calc_err(MAXW'(r_tgt), MAXW'(r_cur), ANGLE_W);
    assign w_ontgt     = (w_err_run.mag <= L_TOL);
    assign w_worse     = (w_err_run.mag >= r_prev);
    assign w_ont_inc   = r_ont + 1'b1;
    assign w_stall_inc = r_stall + 1'b1;

    always_comb begin
        w_goal = (w_err_run.mag > L_SLOW) ? L_MAX : L_MIN;
        w_up   = {1'b0, r_ratio} + L_STEP;
        w_ramp = w_goal;
        if (r_ratio < w_goal) begin
            if (w_up < {1'b0, w_goal}) w_ramp = w_up[PWM_W-1:0];
        end else if ({1'b0, r_ratio} > {1'b0, w_goal} + L_STEP) begin
            w_ramp = r_ratio - L_STEP[PWM_W-1:0];
        end
    end

    always_comb begin
        w_state = r_state;
        w_tgt   = r_tgt;
        w_ratio = r_ratio;
        w_dir   = r_dir;
        w_en    = r_en;
        w_done  = r_done;
        w_fail  = r_fail;
        w_ont   = r_ont;
        w_stall = r_stall;
        w_prev  = r_prev;
        w_req   = 1'b0;
        if (i_abort) begin
            w_state = S_IDLE;
            w_ratio = '0;
            w_en    = 1'b0;
            w_done  = 1'b0;
            w_req   = 1'b1;
        end else if (i_upd) begin
            w_tgt   = i_tgt;
            w_ont   = '0;
            w_stall = '0;
            w_prev  = w_err_new.mag;
            if (r_state != S_RUN) begin
                w_state = S_RUN;
                w_ratio = L_MIN;
                w_dir   = w_err_new.dir;
                w_en    = 1'b1;
                w_done  = 1'b0;
                w_fail  = 1'b0;
                w_req   = 1'b1;
            end
        end else if (r_sample && r_state == S_RUN) begin
            w_prev  = w_err_run.mag;
            w_ont   = w_ontgt ? w_ont_inc : '0;
            w_stall = w_worse ? w_stall_inc : '0;
            if (w_ontgt && w_ont_inc == L_CONS) begin
                w_state = S_DONE;
                w_ratio = '0;
                w_en    = 1'b0;
                w_done  = 1'b1;
                w_req   = 1'b1;
            end else if (w_worse && w_stall_inc == L_STAL) begin
                w_state = S_FAIL;
                w_ratio = '0;
                w_en    = 1'b0;
                w_fail  = 1'b1;
                w_req   = 1'b1;
            end else if (w_err_run.dir != r_dir) begin
                w_ratio = L_MIN;
                w_dir   = w_err_run.dir;
                w_req   = 1'b1;
            end else begin
                w_ratio = w_ramp;
                w_req   = (w_ramp != r_ratio);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_ratio <= '0;
            r_dir   <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_ont   <= '0;
            r_stall <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_state;
            r_tgt   <= w_tgt;
            r_ratio <= w_ratio;
            r_dir   <= w_dir;
            r_en    <= w_en;
            r_done  <= w_done;
            r_fail  <= w_fail;
            r_ont   <= w_ont;
            r_stall <= w_stall;
            r_prev  <= w_prev;
        end
    end

    // A deferred request fires on the ack edge with the latest ratio/dir.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= 1'b0;
            r_defer <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (!r_pend || i_pwm_done) begin
                if (w_req || r_defer) begin
                    r_upd   <= 1'b1;
                    r_pend  <= 1'b1;
                    r_defer <= 1'b0;
                end else begin
                    r_pend  <= 1'b0;
                end
            end else if (w_req) begin
                r_defer <= 1'b1;
            end
        end
    end

    assign o_cur   = r_cur;
    assign o_done  = r_done;
    assign o_fail  = r_fail;
    assign o_en    = r_en;
    assign o_dir   = r_dir;
    assign o_ratio = r_ratio;
    assign o_upd   = r_upd;

endmodule

// File: rtl/steer_ctrl_multi.sv
// Multi-channel steering angle controller: one independent
// steer_ch per motor, with flat bus slicing at the boundary.
module steer_ctrl_multi
    import steer_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int ANGLE_W       = 12,
    parameter int PWM_W         = 8,
    parameter int MIN_PWM       = 40,
    parameter int MAX_PWM       = 200,
    parameter int RAMP_STEP     = 8,
    parameter int SLOW_ZONE     = 128,
    parameter int TOL           = 8,
    parameter int CONSEC        = 3,
    parameter int STALL_SAMPLES = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_CH*ANGLE_W-1:0] i_target_angle,
    input  logic [NUM_CH-1:0]         i_angle_update,
    input  logic [NUM_CH-1:0]         i_abort_angle,
    input  logic [NUM_CH-1:0]         i_enc_valid,
    input  logic [NUM_CH*ANGLE_W-1:0] i_enc_angle,
    output logic [NUM_CH*ANGLE_W-1:0] o_current_angle,
    output logic [NUM_CH-1:0]         o_angle_done,
    output logic [NUM_CH-1:0]         o_startup_fail,
    input  logic [NUM_CH-1:0]         i_pwm_done,
    output logic [NUM_CH-1:0]         o_pwm_enable,
    output logic [NUM_CH-1:0]         o_pwm_dir,
    output logic [NUM_CH*PWM_W-1:0]   o_pwm_ratio,
    output logic [NUM_CH-1:0]         o_pwm_update
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        steer_ch #(
            .ANGLE_W      (ANGLE_W),
            .PWM_W        (PWM_W),
            .MIN_PWM      (MIN_PWM),
            .MAX_PWM      (MAX_PWM),
            .RAMP_STEP    (RAMP_STEP),
            .SLOW_ZONE    (SLOW_ZONE),
            .TOL          (TOL),
            .CONSEC       (CONSEC),
            .STALL_SAMPLES(STALL_SAMPLES)
        ) u_ch (
            .i_clk      (i_clock),
            .i_rst      (i_reset),
            .i_tgt      (i_target_angle[g*ANGLE_W +: ANGLE_W]),
            .i_upd      (i_angle_update[g]),
            .i_abort    (i_abort_angle[g]),
            .i_enc_valid(i_enc_valid[g]),
            .i_enc_angle(i_enc_angle[g*ANGLE_W +: ANGLE_W]),
            .i_pwm_done (i_pwm_done[g]),
            .o_cur      (o_current_angle[g*ANGLE_W +: ANGLE_W]),
            .o_done     (o_angle_done[g]),
            .o_fail     (o_startup_fail[g]),
            .o_en       (o_pwm_enable[g]),
            .o_dir      (o_pwm_dir[g]),
            .o_ratio    (o_pwm_ratio[g*PWM_W +: PWM_W]),
            .o_upd      (o_pwm_update[g])
        );
    end

endmodule

// File: doc/steer_ctrl_multi.md
# steer_ctrl_multi

Parametrised, multi-channel successor to the single-wheel PWM angle controller. It drives NUM_CH steering motors to commanded absolute angles. Each channel takes encoder samples, computes the shortest-path error with wrap-around, ramps a PWM ratio and direction, and reports done or stall per channel. It sits between the FPGA subsystem register block and NUM_CH PWM generators; encoder readers are external and deliver samples via a valid level.

## Interface
- NUM_CH, 4, number of steering channels
- ANGLE_W, 12, encoder angle width (full turn = 2^ANGLE_W counts)
- PWM_W, 8, PWM ratio width
- MIN_PWM, 40, start/creep ratio
- MAX_PWM, 200, cruise ratio ceiling
- RAMP_STEP, 8, ratio increment per sample
- SLOW_ZONE, 128, |err| at or below which target ratio is MIN_PWM
- TOL, 8, |err| at or below which a sample counts as on-target
- CONSEC, 3, consecutive on-target samples required for done
- STALL_SAMPLES, 16, consecutive non-improving samples before fail

- clock  in  1  main clock
- reset  in  1  synchronous, active-high reset
- target_angle  in  NUM_CH*ANGLE_W  per-channel target, channel i at [i*ANGLE_W +: ANGLE_W]
- angle_update  in  NUM_CH  1-cycle pulse, latch target_angle slice and start/retarget
- abort_angle  in  NUM_CH  1-cycle pulse, stop channel
- enc_valid  in  NUM_CH  level from encoder reader, asynchronous, rises when enc_angle slice is stable
- enc_angle  in  NUM_CH*ANGLE_W  raw encoder angles, stable while enc_valid high
- current_angle  out  NUM_CH*ANGLE_W  last captured angle
- angle_done  out  NUM_CH  level, channel on target
- startup_fail  out  NUM_CH  sticky stall flag
- pwm_done  in  NUM_CH  1-cycle ack from PWM generator
- pwm_enable  out  NUM_CH  PWM output enable
- pwm_dir  out  NUM_CH  1 = positive (increasing angle), 0 = negative
- pwm_ratio  out  NUM_CH*PWM_W  high time out of 2^PWM_W-1
- pwm_update  out  NUM_CH  1-cycle request to apply pwm_ratio/pwm_dir

## Operation
- Reset: all outputs 0, all FSMs IDLE, counters 0.
- Sample capture: enc_valid goes through a 2-flop synchroniser. On its rising edge, the enc_angle slice loads into current_angle and a 1-cycle sample event fires.
- Error: diff = (target − current) mod 2^ANGLE_W.
  - If diff[MSB] = 0: dir = 1, mag = diff.
  - Else: dir = 0, mag = 2^ANGLE_W − diff.
  - diff = 2^(ANGLE_W−1) resolves to dir = 0, mag = 2^(ANGLE_W−1).
  - All arithmetic is unsigned, ANGLE_W+1 bits internally.
- FSM per channel has four states: IDLE, RUN, DONE, FAIL.
- IDLE/DONE/FAIL + angle_update:
  - Latch target.
  - Clear angle_done, startup_fail and counters.
  - Set ratio = MIN_PWM, dir from the current error, pwm_enable = 1.
  - Request an update.
  - Go to RUN.
- RUN + angle_update: retarget, clear counters, keep ratio; dir re-evaluated at the next sample.
- RUN + sample event:
  - If mag ≤ TOL: ontgt_cnt++. When ontgt_cnt reaches CONSEC: ratio = 0, pwm_enable = 0, angle_done = 1, request update, go to DONE.
  - If mag > TOL: ontgt_cnt = 0.
  - Dir reversal versus the driven dir: ratio = MIN_PWM immediately, new dir.
  - Otherwise: goal = MAX_PWM if mag > SLOW_ZONE, else MIN_PWM. Ratio steps toward goal by RAMP_STEP, saturating at goal.
  - Stall: if mag ≥ previous mag, stall_cnt++, else stall_cnt = 0. When stall_cnt reaches STALL_SAMPLES: ratio = 0, pwm_enable = 0, startup_fail = 1, request update, go to FAIL.
  - A ratio or dir change requests an update.
- abort_angle in any state: ratio = 0, pwm_enable = 0, angle_done = 0, request update, go to IDLE. startup_fail is retained.
- Same-cycle priority: abort_angle > angle_update > sample event.
- Update handshake: at most one outstanding request per channel.
  - A request with none pending pulses pwm_update the next cycle and sets pending.
  - A request while pending is recorded. It pulses one cycle after pwm_done with the latest ratio/dir.
  - pwm_done clears pending.
  - pwm_done with nothing pending is ignored.
- DONE holds angle_done high and ignores samples, apart from updating current_angle.

## Timing
- enc_valid rise → current_angle valid: 3 cycles (2 sync + capture).
- Sample event → pwm_ratio/pwm_dir registered: +1 cycle. pwm_update pulse: same cycle as new ratio when not pending.
- angle_update → pwm_enable = 1 and pwm_update: 1 cycle later.
- Done/fail/abort: pwm_enable and angle_done/startup_fail change 1 cycle after the causing event; no handshake gating.
- Channels are fully independent; there is no shared arbitration.

## Structure
- Package steer_pkg holds the FSM state enum (IDLE, RUN, DONE, FAIL) and the error/direction helper function.
- Natural sub-module: steer_ch (one channel: sync, capture, FSM, ramp, handshake). The top is a generate loop over NUM_CH plus port slicing.

## Test plan
- Basic move, ch0: current = 100, target = 1000 → dir = 1, ratio ramps 40, 48, … to 200. After mag ≤ 8 for 3 samples: angle_done = 1, pwm_enable = 0, ratio = 0.
- Wrap-around: current = 4090, target = 10 → dir = 1, mag = 16. Current = 10, target = 4090 → dir = 0, mag = 16. Also check diff = 2048 → dir = 0.
- Stall: hold enc_angle at 500 with target 1500, 16 samples → startup_fail = 1, pwm_enable = 0. Then angle_update clears startup_fail.
- Handshake: withhold pwm_done across 3 ratio changes → single pwm_update. After pwm_done, one pulse carries the latest ratio.
- Abort vs update same cycle on ch2 in RUN → IDLE, pwm_enable = 0; other channels unaffected.
- Reset mid-RUN → all outputs 0 the next cycle, FSM IDLE.
